// File: rtl/diff_accum.sv
// diff_accum: multi-channel comparator integrator. Each channel counts +1/-1
// per cycle of its synchronised comparator bit over a programmable window,
// then the results are streamed out one channel per valid/ready handshake.
module diff_accum #(
    parameter int N_CH       = 4,
    parameter int CNT_W      = 12,
    parameter int WIN_W      = 8,
    parameter int SETTLE_CYC = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ena,
    input  logic [N_CH-1:0]         cmp_in,
    input  logic                    start,
    input  logic                    abort,
    input  logic                    cont,
    input  logic [WIN_W-1:0]        win_len,
    output logic                    busy,
    output logic signed [CNT_W-1:0] out_data,
    output logic [2:0]              out_ch,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    done
);

    localparam int SCW = $clog2(SETTLE_CYC + 1);
    localparam logic signed [CNT_W-1:0] ACC_MAX = {1'b0, {(CNT_W-1){1'b1}}};
    localparam logic signed [CNT_W-1:0] ACC_MIN = {1'b1, {(CNT_W-1){1'b0}}};
    localparam logic signed [CNT_W-1:0] ACC_ONE = CNT_W'(1);

    typedef enum logic [1:0] {IDLE, SETTLE, ACCUM, READOUT} state_e;

    state_e                  state_q, state_d;
    logic [SCW-1:0]          scnt_q, scnt_d;
    logic [WIN_W:0]          wcnt_q, wcnt_d;
    logic [WIN_W-1:0]        win_q, win_d;
    logic [2:0]              ch_q, ch_d;
    logic                    vld_q, vld_d;
    logic signed [CNT_W-1:0] data_q, data_d;
    logic                    done_q, done_d;
    logic                    acc_clr, acc_en;

    logic [N_CH-1:0]         sync1_q, sync2_q;
    logic signed [CNT_W-1:0] acc_q [N_CH];

    logic [WIN_W:0]          win_full;
    logic [2:0]              rd_sel;
    logic signed [CNT_W-1:0] rd_data;

    // Two-flop synchroniser for the asynchronous comparator outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else if (ena) begin
            sync1_q <= cmp_in;
            sync2_q <= sync1_q;
        end
    end

    // Per-channel saturating up/down accumulators
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_CH; i++) begin
            if (!rst_n) begin
                acc_q[i] <= '0;
            end else if (ena) begin
                if (acc_clr) begin
                    acc_q[i] <= '0;
                end else if (acc_en) begin
                    if (sync2_q[i]) begin
                        if (acc_q[i] != ACC_MAX) acc_q[i] <= acc_q[i] + ACC_ONE;
                    end else begin
                        if (acc_q[i] != ACC_MIN) acc_q[i] <= acc_q[i] - ACC_ONE;
                    end
                end
            end
        end
    end

    // Readout mux: first load uses the current channel, later loads the next one
    always_comb begin
        rd_sel  = vld_q ? ch_q + 3'd1 : ch_q;
        rd_data = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (rd_sel == 3'(i)) rd_data = acc_q[i];
        end
    end

    // A zero window field means the full 2^WIN_W cycles
    assign win_full = (win_q == '0) ? {1'b1, {WIN_W{1'b0}}} : {1'b0, win_q};

    // FSM and output register state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            scnt_q  <= '0;
            wcnt_q  <= '0;
            win_q   <= '0;
            ch_q    <= '0;
            vld_q   <= 1'b0;
            data_q  <= '0;
            done_q  <= 1'b0;
        end else if (ena) begin
            state_q <= state_d;
            scnt_q  <= scnt_d;
            wcnt_q  <= wcnt_d;
            win_q   <= win_d;
            ch_q    <= ch_d;
            vld_q   <= vld_d;
            data_q  <= data_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic; abort overrides everything except start in IDLE
    always_comb begin
        state_d = state_q;
        scnt_d  = scnt_q;
        wcnt_d  = wcnt_q;
        win_d   = win_q;
        ch_d    = ch_q;
        vld_d   = vld_q;
        data_d  = data_q;
        done_d  = 1'b0;
        acc_clr = 1'b0;
        acc_en  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SETTLE;
                    win_d   = win_len;
                    scnt_d  = SCW'(SETTLE_CYC);
                    acc_clr = 1'b1;
                end
            end
            SETTLE: begin
                if (scnt_q <= SCW'(1)) begin
                    state_d = ACCUM;
                    wcnt_d  = win_full;
                end else begin
                    scnt_d = scnt_q - SCW'(1);
                end
            end
            ACCUM: begin
                acc_en = 1'b1;
                if (wcnt_q == (WIN_W+1)'(1)) begin
                    state_d = READOUT;
                    ch_d    = '0;
                    vld_d   = 1'b0;
                end else begin
                    wcnt_d = wcnt_q - (WIN_W+1)'(1);
                end
            end
            READOUT: begin
                if (!vld_q) begin
                    // One register stage between the last accumulate and the first word
                    vld_d  = 1'b1;
                    data_d = rd_data;
                end else if (out_ready) begin
                    if (ch_q == 3'(N_CH-1)) begin
                        done_d = 1'b1;
                        vld_d  = 1'b0;
                        ch_d   = '0;
                        if (cont) begin
                            state_d = SETTLE;
                            scnt_d  = SCW'(SETTLE_CYC);
                            acc_clr = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        ch_d   = ch_q + 3'd1;
                        data_d = rd_data;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (abort && state_q != IDLE) begin
            state_d = IDLE;
            vld_d   = 1'b0;
            ch_d    = '0;
            done_d  = 1'b0;
            acc_clr = 1'b0;
            acc_en  = 1'b0;
        end
    end

    assign busy      = (state_q != IDLE);
    assign out_data  = data_q;
    assign out_ch    = ch_q;
    assign out_valid = vld_q;
    assign done      = done_q;

endmodule

// File: tb/tb_diff_accum.sv
// Directed bench for diff_accum: a default-width instance and a 4-bit
// accumulator instance share all inputs so saturation is visible alongside.
module tb_diff_accum;

    logic       clk = 1'b0;
    logic       rst_n, ena, start, abort, cont, out_ready;
    logic [3:0] cmp_in;
    logic [7:0] win_len;

    logic              busy0, vld0, done0;
    logic [2:0]        ch0;
    logic signed [11:0] data0;
    logic              busy1, vld1, done1;
    logic [2:0]        ch1;
    logic signed [3:0] data1;

    int n_vec = 0;
    int n_bad = 0;
    int exp0[4];
    int exp1[4];
    int lat;
    int cnt;

    always #5 clk = ~clk;

    diff_accum #(.N_CH(4), .CNT_W(12), .WIN_W(8), .SETTLE_CYC(2)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .cmp_in(cmp_in), .start(start),
        .abort(abort), .cont(cont), .win_len(win_len), .busy(busy0),
        .out_data(data0), .out_ch(ch0), .out_valid(vld0), .out_ready(out_ready),
        .done(done0)
    );

    diff_accum #(.N_CH(4), .CNT_W(4), .WIN_W(8), .SETTLE_CYC(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .cmp_in(cmp_in), .start(start),
        .abort(abort), .cont(cont), .win_len(win_len), .busy(busy1),
        .out_data(data1), .out_ch(ch1), .out_valid(vld1), .out_ready(out_ready),
        .done(done1)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_conv(input logic [7:0] w);
        win_len = w;
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    // Wait for the first word, then take all four words, optionally stalling each
    task automatic readout(input int stall, output int l);
        l = 0;
        while (!vld0 && l < 400) begin
            tick();
            l++;
        end
        if (!vld0) begin
            chk("valid_timeout", 0, 1);
            return;
        end
        for (int k = 0; k < 4; k++) begin
            if (stall > 0) begin
                out_ready = 1'b0;
                for (int s = 0; s < stall; s++) begin
                    tick();
                    chk("stall_vld", vld0, 1);
                    chk("stall_ch", ch0, k);
                    chk("stall_data", data0, exp0[k]);
                end
                out_ready = 1'b1;
            end
            chk("vld", vld0, 1);
            chk("ch", ch0, k);
            chk("data0", data0, exp0[k]);
            chk("data1", data1, exp1[k]);
            chk("ch1", ch1, k);
            tick();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; ena = 1'b1; start = 1'b0; abort = 1'b0; cont = 1'b0;
        out_ready = 1'b1; cmp_in = 4'b0000; win_len = 8'd0;
        tick(); tick();
        chk("rst_busy", busy0, 0);
        chk("rst_vld", vld0, 0);
        chk("rst_done", done0, 0);
        chk("rst_ch", ch0, 0);
        chk("rst_data", data0, 0);
        rst_n = 1'b1;
        tick();

        // Basic conversion, with a frozen done pulse afterwards
        cmp_in = 4'b0101;
        exp0 = '{10, -10, 10, -10};
        exp1 = '{7, -8, 7, -8};
        start_conv(8'd10);
        chk("basic_busy", busy0, 1);
        readout(0, lat);
        chk("basic_latency", lat, 13);
        chk("basic_done", done0, 1);
        chk("basic_idle", busy0, 0);
        chk("basic_vld_drop", vld0, 0);
        ena = 1'b0;
        tick(); tick(); tick();
        chk("ena_done_hold", done0, 1);
        ena = 1'b1;
        tick();
        chk("done_once", done0, 0);

        // Saturation on the 4-bit instance
        cmp_in = 4'b1111;
        exp0 = '{20, 20, 20, 20};
        exp1 = '{7, 7, 7, 7};
        start_conv(8'd20);
        readout(0, lat);
        cmp_in = 4'b0000;
        exp0 = '{-20, -20, -20, -20};
        exp1 = '{-8, -8, -8, -8};
        tick();
        start_conv(8'd20);
        readout(0, lat);
        tick();

        // Window length 0 = 256 cycles
        cmp_in = 4'b1111;
        exp0 = '{256, 256, 256, 256};
        exp1 = '{7, 7, 7, 7};
        start_conv(8'd0);
        readout(0, lat);
        chk("wrap_latency", lat, 259);
        tick();

        // 128 ones then 128 zeros
        cmp_in = 4'b1111;
        exp0 = '{0, 0, 0, 0};
        exp1 = '{-8, -8, -8, -8};
        start_conv(8'd0);
        repeat (128) tick();
        cmp_in = 4'b0000;
        readout(0, lat);
        tick();

        // Backpressure
        cmp_in = 4'b0101;
        exp0 = '{10, -10, 10, -10};
        exp1 = '{7, -8, 7, -8};
        start_conv(8'd10);
        readout(5, lat);
        chk("bp_done", done0, 1);
        tick();

        // Abort on the third accumulate edge
        start_conv(8'd10);
        repeat (4) tick();
        chk("abort_pre_busy", busy0, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", busy0, 0);
        chk("abort_vld", vld0, 0);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (vld0 || done0 || busy0) cnt++;
            tick();
        end
        chk("abort_quiet", cnt, 0);

        // Restart after abort
        cmp_in = 4'b1111;
        exp0 = '{5, 5, 5, 5};
        exp1 = '{5, 5, 5, 5};
        tick();
        start_conv(8'd5);
        readout(0, lat);
        chk("restart_done", done0, 1);
        tick();

        // Continuous mode: two back-to-back conversions
        cmp_in = 4'b0101;
        exp0 = '{10, -10, 10, -10};
        exp1 = '{7, -8, 7, -8};
        cont = 1'b1;
        start_conv(8'd10);
        readout(0, lat);
        chk("cont_done1", done0, 1);
        chk("cont_no_idle", busy0, 1);
        cont = 1'b0;
        readout(0, lat);
        chk("cont_latency2", lat, 13);
        chk("cont_done2", done0, 1);
        chk("cont_idle", busy0, 0);
        tick();

        // Reset in the middle of a readout
        start_conv(8'd10);
        readout_partial();
        rst_n = 1'b0;
        tick();
        chk("mrst_busy", busy0, 0);
        chk("mrst_vld", vld0, 0);
        chk("mrst_done", done0, 0);
        chk("mrst_ch", ch0, 0);
        chk("mrst_data", data0, 0);
        rst_n = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    // Take the first two words and stall on the third
    task automatic readout_partial();
        int l;
        l = 0;
        while (!vld0 && l < 100) begin
            tick();
            l++;
        end
        chk("part_vld", vld0, 1);
        tick(); tick();
        out_ready = 1'b0;
        tick();
        chk("part_ch", ch0, 2);
        out_ready = 1'b1;
    endtask

endmodule
